// File: rtl/hs4_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs4_pkg : shared state encoding and default sizing for the hs4 blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package hs4_pkg;

  localparam int HS4_DATA_W      = 32;
  localparam int HS4_DEPTH       = 4;
  localparam int HS4_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STALL   = 3'd1,
    CAPTURE = 3'd2,
    ACK_HI  = 3'd3,
    ACK_LO  = 3'd4
  } hs4_state_e;

endpackage
`default_nettype wire

// File: rtl/hs4_rx_sink_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs4_rx_sink_if : REQ/ACK producer side plus valid/ready consumer side
// Rev 1.0
// ----------------------------------------------------------------------------
interface hs4_rx_sink_if
  import hs4_pkg::*;
#(
  parameter int DATA_W = HS4_DATA_W,
  parameter int DEPTH  = HS4_DEPTH
);

  logic                   BtoR_REQ;
  logic [DATA_W-1:0]      DO;
  logic                   RtoB_ACK;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;
  logic [31:0]            rx_count;

  // master: producer and consumer (the environment); slave: the sink
  modport master (
    output BtoR_REQ, DO, out_ready,
    input  RtoB_ACK, out_valid, out_data, level, rx_count
  );

  modport slave (
    input  BtoR_REQ, DO, out_ready,
    output RtoB_ACK, out_valid, out_data, level, rx_count
  );

endinterface
`default_nettype wire

// File: rtl/hs4_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs4_sync_fifo : first-word fall-through FIFO, extra-MSB pointer scheme
// Rev 1.0
// ----------------------------------------------------------------------------
module hs4_sync_fifo
  import hs4_pkg::*;
#(
  parameter int DATA_W = HS4_DATA_W,
  parameter int DEPTH  = HS4_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push;
  logic              do_pop;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;

  // A pop while full frees a slot only after the edge, so push is gated on the registered full
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/hs4_rx_sink.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs4_rx_sink : four-phase REQ/ACK receiver feeding a valid/ready FIFO port
// Rev 1.0
// ----------------------------------------------------------------------------
module hs4_rx_sink
  import hs4_pkg::*;
#(
  parameter int DATA_W      = HS4_DATA_W,
  parameter int DEPTH       = HS4_DEPTH,
  parameter int SYNC_STAGES = HS4_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  hs4_rx_sink_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  hs4_state_e             state_q, state_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rx_count_q, rx_count_d;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.BtoR_REQ};
  assign req_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    rx_count_d = rx_count_q;
    case (state_q)
      IDLE: begin
        if (req_s) state_d = fifo_full ? STALL : CAPTURE;
      end
      STALL: begin
        if (!fifo_full) state_d = CAPTURE;
      end
      CAPTURE: begin
        push       = 1'b1;
        rx_count_d = rx_count_q + 32'd1;
        state_d    = ACK_HI;
      end
      ACK_HI: begin
        if (!req_s) state_d = ACK_LO;
      end
      ACK_LO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // ACK is registered off the next state so it rises with the ACK_HI entry
    ack_d = (state_d == ACK_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      rx_count_q <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      rx_count_q <= rx_count_d;
    end
  end

  hs4_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.DO),
    .pop       (bus.out_ready),
    .head_data (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (bus.level)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.RtoB_ACK  = ack_q;
  assign bus.rx_count  = rx_count_q;

endmodule
`default_nettype wire
